// File: rtl/cordic_pkg.sv
// cordic_pkg: shared width default, FSM state type and quadrant angle constants
package cordic_pkg;
    localparam int WIDTH = 24;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] ANGLE_0   = 24'h000000;
    localparam logic [WIDTH-1:0] ANGLE_90  = 24'h400000;
    localparam logic [WIDTH-1:0] ANGLE_180 = 24'h800000;
    localparam logic [WIDTH-1:0] ANGLE_270 = 24'hC00000;
endpackage

// File: rtl/sample_strobe_gen.sv
// sample_strobe_gen: sample-period down-counter producing one strobe every div+1 enabled clocks
// Ports: clk, reset (sync, active-high), clr (zero the counter), en (count enable),
//        div (period minus 1, reloaded on each strobe), strobe (counter at zero while enabled)
module sample_strobe_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);
    logic [DIV_W-1:0] div_cnt;
    assign strobe = en && div_cnt == '0;
    always_ff @(posedge clk) begin
        if (reset || clr) div_cnt <= '0;
        else if (en) div_cnt <= (div_cnt == '0) ? div : div_cnt - 1'b1;
    end
endmodule

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: chirp-capable phase accumulator emitting angle samples to a CORDIC stage
// Ports: clk, reset (sync, active-high); cfg_valid/cfg_ready handshake with cfg_freq, cfg_step,
//        cfg_phase, cfg_count (0 = continuous), cfg_div (period minus 1); start/stop controls;
//        angle_o/angle_valid_o sample output; busy_o (RUN), done_o (one-cycle end-of-burst pulse)
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int WIDTH = cordic_pkg::WIDTH,
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_freq,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_phase,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] angle_o,
    output logic             angle_valid_o,
    output logic             busy_o,
    output logic             done_o
);
    state_t state, nxt;
    logic [WIDTH-1:0] sh_freq, sh_step, sh_phase, phase_acc, freq_acc;
    logic [CNT_W-1:0] sh_count, sample_cnt;
    logic [DIV_W-1:0] sh_div;
    logic accept, go, fin, strobe, fire;
    assign cfg_ready = state == IDLE;
    assign busy_o    = state == RUN;
    assign done_o    = state == DONE;
    sample_strobe_gen #(.DIV_W(DIV_W)) u_strobe (
        .clk(clk), .reset(reset), .clr(go), .en(busy_o), .div(sh_div), .strobe(strobe)
    );
    // The burst ends one cycle after its last sample, so that cycle must not emit another.
    always_comb begin
        accept = cfg_ready && cfg_valid;
        go     = cfg_ready && start && !cfg_valid;
        fin    = sh_count != '0 && sample_cnt == sh_count;
        fire   = busy_o && strobe && !stop && !fin;
        nxt    = go ? RUN :
                 (busy_o && (stop || fin)) ? DONE :
                 done_o ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            angle_o       <= '0;
            angle_valid_o <= 1'b0;
            sh_freq       <= '0;
            sh_step       <= '0;
            sh_phase      <= '0;
            sh_count      <= '0;
            sh_div        <= '0;
            phase_acc     <= '0;
            freq_acc      <= '0;
            sample_cnt    <= '0;
        end else begin
            state         <= nxt;
            angle_valid_o <= fire;
            if (accept) begin
                sh_freq  <= cfg_freq;
                sh_step  <= cfg_step;
                sh_phase <= cfg_phase;
                sh_count <= cfg_count;
                sh_div   <= cfg_div;
            end
            if (go) begin
                phase_acc  <= '0;
                freq_acc   <= sh_freq;
                sample_cnt <= '0;
            end
            if (fire) begin
                angle_o    <= phase_acc + sh_phase;
                phase_acc  <= phase_acc + freq_acc;
                freq_acc   <= freq_acc + sh_step;
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb_cordic_phase_gen: scoreboard bench comparing sample values, sample edges and done pulses to a closed-form model
module tb_cordic_phase_gen;
    logic clk = 0, reset = 1, cfg_valid = 0, start = 0, stop = 0;
    logic [23:0] cfg_freq = 0, cfg_step = 0, cfg_phase = 0;
    logic [15:0] cfg_count = 0;
    logic [7:0]  cfg_div = 0;
    logic cfg_ready, angle_valid_o, busy_o, done_o;
    logic [23:0] angle_o;
    cordic_phase_gen dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_step(cfg_step), .cfg_phase(cfg_phase),
        .cfg_count(cfg_count), .cfg_div(cfg_div), .start(start), .stop(stop),
        .angle_o(angle_o), .angle_valid_o(angle_valid_o), .busy_o(busy_o), .done_o(done_o)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct { logic [23:0] a; int t; } exp_t;
    exp_t q[$];
    int dq[$];
    int total = 0, bad = 0;
    logic [23:0] sh_freq = 0, sh_step = 0, sh_phase = 0;
    logic [15:0] sh_count = 0;
    logic [7:0]  sh_div = 0;
    task automatic chk(input string n, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, req, cyc);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    // Sample k of a burst: phase + k*freq + step*k(k-1)/2, modulo the full circle.
    function automatic logic [23:0] angle_at(input int k);
        logic [63:0] kk, v;
        kk = 64'(k);
        v = 64'(sh_phase) + kk * 64'(sh_freq) + (kk * (kk - 1) / 2) * 64'(sh_step);
        return v[23:0];
    endfunction
    exp_t e;
    bit prev_done = 0;
    always @(negedge clk) begin
        if (prev_done) begin
            chk("idle_after_done", cfg_ready, 1);
            chk("done_width", done_o, 0);
        end
        prev_done = done_o;
        if (angle_valid_o) begin
            if (q.size() == 0) chk("spurious_strobe", 1, 0);
            else begin
                e = q.pop_front();
                chk("angle", angle_o, e.a);
                chk("strobe_edge", cyc, e.t);
            end
        end
        if (done_o) begin
            chk("busy_in_done", busy_o, 0);
            if (dq.size() == 0) chk("spurious_done", 1, 0);
            else chk("done_edge", cyc, dq.pop_front());
        end
    end
    task automatic run_burst(input bit do_cfg, input logic [23:0] f, s, p, input logic [15:0] c,
                             input logic [7:0] d, input int stop_at, input bit bad_cfg);
        int e0, n;
        if (do_cfg) begin
            cfg_valid = 1; cfg_freq = f; cfg_step = s; cfg_phase = p; cfg_count = c; cfg_div = d;
            sh_freq = f; sh_step = s; sh_phase = p; sh_count = c; sh_div = d;
            tick();
            cfg_valid = 0;
        end
        start = 1;
        e0 = cyc + 1;
        tick();
        start = 0;
        n = (stop_at > 0) ? (stop_at - 1 + int'(sh_div)) / (int'(sh_div) + 1) : int'(sh_count);
        for (int k = 0; k < n; k++) q.push_back('{a: angle_at(k), t: e0 + 1 + k * (int'(sh_div) + 1)});
        dq.push_back(stop_at > 0 ? e0 + stop_at : e0 + 2 + (n - 1) * (int'(sh_div) + 1));
        if (bad_cfg) begin
            cfg_valid = 1; cfg_freq = 24'hABCDEF; cfg_count = 16'd1;
            chk("ready_in_run", cfg_ready, 0);
            tick();
            cfg_valid = 0;
        end
        if (stop_at > 0) begin
            while (cyc < e0 + stop_at - 1) tick();
            stop = 1;
            tick();
            stop = 0;
        end
        for (int i = 0; i < 4000 && !(cfg_ready && dq.size() == 0); i++) tick();
        tick();
        chk("ready_idle", cfg_ready, 1);
        chk("queues_empty", q.size() + dq.size(), 0);
    endtask
    initial begin
        int e0;
        repeat (3) tick();
        chk("rst_angle", angle_o, 0);
        chk("rst_valid", angle_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", cfg_ready, 1);
        reset = 0;
        repeat (10) tick();
        run_burst(1, 24'h008000, 0, 0, 4, 0, 0, 0);
        run_burst(1, 24'h400000, 0, 24'hC00000, 3, 0, 0, 0);
        run_burst(1, 24'h000010, 0, 0, 0, 2, 14, 0);
        run_burst(1, 24'h000100, 24'h000100, 0, 4, 0, 0, 0);
        run_burst(1, 24'h000300, 24'hFFFF00, 0, 3, 0, 0, 1);
        run_burst(0, 0, 0, 0, 0, 0, 0, 0);
        cfg_valid = 1; start = 1; cfg_freq = 24'h012345; cfg_step = 24'h000007; cfg_phase = 24'h800000;
        cfg_count = 5; cfg_div = 1;
        sh_freq = cfg_freq; sh_step = cfg_step; sh_phase = cfg_phase; sh_count = cfg_count; sh_div = cfg_div;
        tick();
        cfg_valid = 0; start = 0;
        chk("start_with_cfg_busy", busy_o, 0);
        run_burst(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_burst(1, 24'($urandom), 24'($urandom), 24'($urandom), 16'($urandom_range(1, 6)),
                      8'($urandom_range(0, 3)), 0, 0);
        for (int i = 0; i < 3; i++)
            run_burst(1, 24'($urandom), 24'($urandom), 24'($urandom), 0,
                      8'($urandom_range(0, 3)), int'($urandom_range(2, 20)), 0);
        cfg_valid = 1; cfg_freq = 24'h001234; cfg_step = 0; cfg_phase = 24'h000100; cfg_count = 0; cfg_div = 0;
        sh_freq = cfg_freq; sh_step = 0; sh_phase = cfg_phase; sh_count = 0; sh_div = 0;
        tick();
        cfg_valid = 0; start = 1; e0 = cyc + 1;
        tick();
        start = 0;
        for (int k = 0; k < 2; k++) q.push_back('{a: angle_at(k), t: e0 + 1 + k});
        while (cyc < e0 + 2) tick();
        reset = 1;
        tick();
        chk("midrst_valid", angle_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_ready", cfg_ready, 1);
        chk("midrst_angle", angle_o, 0);
        tick();
        reset = 0;
        sh_freq = 0; sh_step = 0; sh_phase = 0; sh_count = 0; sh_div = 0;
        repeat (10) tick();
        chk("midrst_queues", q.size() + dq.size(), 0);
        run_burst(0, 0, 0, 0, 0, 0, 4, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
